// File: rtl/occupancy_reader.sv
// Read side of the occupancy grid: fetches the 2x2 cell neighbourhood of a query point
// through the shared single-port grid RAM, yielding to the writer and masking off-map cells.
module occupancy_reader #(
   parameter int unsigned MAP_WIDTH  = 256,
   parameter int unsigned MAP_HEIGHT = 256,
   parameter int unsigned WORD_WIDTH = 8,
   parameter logic [WORD_WIDTH-1:0] OOB_VALUE = '0
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic                                     query_valid,
   output logic                                     query_ready,
   input  logic [$clog2(MAP_WIDTH)-1:0]             query_x,
   input  logic [$clog2(MAP_HEIGHT)-1:0]            query_y,
   input  logic                                     writer_busy,
   output logic                                     ram_read_enable,
   output logic [$clog2(MAP_WIDTH*MAP_HEIGHT)-1:0]  ram_address,
   input  logic [WORD_WIDTH-1:0]                    ram_data,
   output logic [WORD_WIDTH-1:0]                    cell_00,
   output logic [WORD_WIDTH-1:0]                    cell_10,
   output logic [WORD_WIDTH-1:0]                    cell_01,
   output logic [WORD_WIDTH-1:0]                    cell_11,
   output logic                                     result_valid
);

   localparam int unsigned XW = $clog2(MAP_WIDTH);
   localparam int unsigned YW = $clog2(MAP_HEIGHT);
   localparam int unsigned AW = $clog2(MAP_WIDTH * MAP_HEIGHT);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

   state_e                state_q, state_d;
   logic [XW-1:0]         x_q;
   logic [YW-1:0]         y_q;
   logic [1:0]            slot_q, slot_d;
   logic                  pend_valid_q;
   logic [1:0]            pend_slot_q;
   logic [AW-1:0]         addr_q;
   logic [WORD_WIDTH-1:0] cell_q [4];

   logic [XW:0]           col;
   logic [YW:0]           row;
   logic [AW-1:0]         addr_calc;
   logic                  in_bounds;
   logic                  strobe;
   logic                  advance;

   // Neighbour coordinates carry one extra bit so x+1 / y+1 never wrap back onto the map.
   always_comb begin
      col       = {1'b0, x_q} + (XW+1)'(slot_q[0]);
      row       = {1'b0, y_q} + (YW+1)'(slot_q[1]);
      in_bounds = (32'(col) < MAP_WIDTH) && (32'(row) < MAP_HEIGHT);
      addr_calc = AW'(row) * AW'(MAP_WIDTH) + AW'(col);
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      strobe  = 1'b0;
      advance = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (query_valid) begin
               state_d = StFetch;
               slot_d  = 2'd0;
            end
         end
         StFetch: begin
            if (!writer_busy) begin
               advance = 1'b1;
               strobe  = in_bounds;
               slot_d  = slot_q + 2'd1;
               if (slot_q == 2'd3) state_d = StDrain;
            end
         end
         StDrain: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      query_ready     = (state_q == StIdle);
      result_valid    = (state_q == StDone);
      ram_read_enable = strobe;
      ram_address     = strobe ? addr_calc : addr_q;
      cell_00         = cell_q[0];
      cell_10         = cell_q[1];
      cell_01         = cell_q[2];
      cell_11         = cell_q[3];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         slot_q       <= 2'd0;
         x_q          <= '0;
         y_q          <= '0;
         pend_valid_q <= 1'b0;
         pend_slot_q  <= 2'd0;
         addr_q       <= '0;
         for (int i = 0; i < 4; i++) cell_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         pend_valid_q <= strobe;
         pend_slot_q  <= slot_q;
         addr_q       <= ram_address;
         if (query_valid && state_q == StIdle) begin
            x_q <= query_x;
            y_q <= query_y;
         end
         // Pending capture targets the previous slot, OOB fill the current one: never the same.
         if (pend_valid_q) cell_q[pend_slot_q] <= ram_data;
         if (advance && !in_bounds) cell_q[slot_q] <= OOB_VALUE;
      end
   end

endmodule

// File: doc/occupancy_reader.md
Name: occupancy_reader

Overview:
- Read-side counterpart of the occupancy grid writer.
- Serves point queries from the scan-matching stage and returns the 2x2 neighbourhood of map cells: (x,y), (x+1,y), (x,y+1) and (x+1,y+1).
- Issues four sequential reads to the single-port grid RAM, which has a 1-cycle read latency.
- Yields the RAM to the writer whenever the writer is busy, and substitutes a fixed value for cells that fall outside the map.

Parameters:
- MAP_WIDTH, 256, number of cells per row; x range 0..MAP_WIDTH-1.
- MAP_HEIGHT, 256, number of rows; y range 0..MAP_HEIGHT-1.
- WORD_WIDTH, 8, bits per cell word.
- OOB_VALUE, 0, word returned for any cell outside the map.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- query_valid  in  1  query request.
- query_ready  out  1  block idle and able to accept a query.
- query_x  in  $clog2(MAP_WIDTH)  base cell column.
- query_y  in  $clog2(MAP_HEIGHT)  base cell row.
- writer_busy  in  1  busy output of the occupancy writer; RAM owned by the writer while high.
- ram_read_enable  out  1  read strobe to grid RAM.
- ram_address  out  $clog2(MAP_WIDTH*MAP_HEIGHT)  read address = y*MAP_WIDTH + x.
- ram_data  in  WORD_WIDTH  RAM read data, valid the cycle after the strobe.
- cell_00, cell_10, cell_01, cell_11  out  WORD_WIDTH each  cells (x,y), (x+1,y), (x,y+1), (x+1,y+1).
- result_valid  out  1  one-cycle pulse; cell outputs are valid from this cycle onwards.

Behaviour:
- Reset:
  - State returns to IDLE and the slot counter clears.
  - query_ready=1; ram_read_enable=0; ram_address=0; result_valid=0; all cell_* = 0.
  - A reset mid-query abandons the query, and no result_valid pulse is produced for it.
- Query acceptance:
  - A query is accepted on an edge where query_valid && query_ready.
  - query_x and query_y are registered at acceptance; the inputs are don't-care afterwards.
  - query_ready is 1 only in IDLE.
- States: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
- FETCH (2-bit slot counter k=0..3, slot order 00,10,01,11):
  - If writer_busy=1: no strobe is issued and k holds (stall).
  - Else, if slot k is in bounds: ram_read_enable=1 and ram_address is driven for that slot.
  - Else (slot k out of bounds): no strobe; OOB_VALUE is written into that slot's output register.
  - In either non-stall case, k increments; leaving slot 3 moves the block to DRAIN.
- Data capture:
  - Data for a strobe issued in cycle t is captured from ram_data at the end of cycle t+1 into the matching cell_* register.
  - Capture happens even if writer_busy rises in t+1. The pending-capture tag (valid bit plus slot index) is one register stage.
- DRAIN: one cycle; captures slot 3 if it was read; no strobe.
- DONE: result_valid=1 for exactly one cycle, then IDLE.
- Output stability: cell_* hold their values until overwritten by the next query's captures. Consumers must sample on result_valid.
- Latency without stalls: accept at the end of cycle 0; FETCH cycles 1-4; DRAIN cycle 5; result_valid in cycle 6; query_ready=1 in cycle 7. Each stall cycle adds exactly 1.
- Bounds:
  - A slot is out of bounds if its column >= MAP_WIDTH or its row >= MAP_HEIGHT.
  - x+1 and y+1 are computed one bit wider to avoid wrap-around.
  - A base cell outside the map (possible when MAP_WIDTH is not a power of 2) makes all four slots OOB.
- Address arithmetic: row*MAP_WIDTH + col, computed at full address width with no truncation. ram_address holds its last value while no strobe is issued.
- writer_busy during IDLE/DRAIN/DONE has no effect. The reader never strobes while writer_busy=1 in the same cycle.

Test Plan:
- Setup for all scenarios: MAP_WIDTH=MAP_HEIGHT=8; RAM model mem[a]=a+100; accept at cycle 0.
- Query (2,3):
  - Strobes at cycles 1-4 with addresses 26,27,34,35.
  - result_valid in cycle 6 with cell_00=126, cell_10=127, cell_01=134, cell_11=135.
  - query_ready=0 during cycles 1-6.
- Right edge, query (7,3):
  - Strobes only at cycles 1 and 3 (addresses 31,39).
  - cell_00=131, cell_10=0, cell_01=139, cell_11=0; result_valid in cycle 6.
- Corner, query (7,7): single strobe at address 63; cell_00=163, others 0; result_valid in cycle 6.
- Writer contention, query (2,3) with writer_busy=1 in cycles 2-3:
  - No strobe in cycles 2-3; slot-0 data is still captured in cycle 2.
  - Addresses in order 26,27,34,35; result_valid in cycle 8; values as in the (2,3) scenario.
- Reset mid-query:
  - Assert reset in cycle 3 of a (2,3) query: all outputs are 0 immediately and no result_valid pulse occurs.
  - After release, a (0,0) query returns 100,101,108,109.
- Back-to-back:
  - query_valid held high with (1,1) then (4,4): the second query is accepted in cycle 7.
  - Its result_valid arrives in cycle 13 with 136,137,144,145; the (1,1) values (109,110,117,118) hold until then.
